// File: rtl/lift_car_drive.sv
// Car-side executor for the 4-floor lift: moves toward the target floor code, opens the door on arrival.
// Optional LIFT_DOOR_HOLD_EN adds a door_hold input that keeps the door open while asserted.
//
// state | meaning
// IDLE  | parked with door closed, target compared against floor every cycle
// MV_UP | travelling upward, floor steps +1 every TRAVEL_TICKS cycles
// MV_DN | travelling downward, floor steps -1 every TRAVEL_TICKS cycles
// DOOR  | stopped with door open for DOOR_TICKS cycles, target ignored
module lift_car_drive #(
  parameter int TRAVEL_TICKS = 50_000_000,
  parameter int DOOR_TICKS   = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic z1,
  input  logic z2,
  input  logic z3,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic door_hold,
`endif
  output logic f1,
  output logic f2,
  output logic f3,
  output logic up,
  output logic down,
  output logic door_open,
  output logic arrive
);

  typedef enum logic [1:0] {IDLE, MV_UP, MV_DN, DOOR} state_t;

  localparam logic [25:0] TRAVEL_LAST = 26'(TRAVEL_TICKS - 1);
  localparam logic [26:0] DOOR_LAST   = 27'(DOOR_TICKS - 1);

  state_t      state;
  logic [2:0]  floor;
  logic [2:0]  target;
  logic [2:0]  floor_up;
  logic [2:0]  floor_dn;
  logic        target_ok;
  logic        hold;
  logic [25:0] travel_cnt;
  logic [26:0] door_cnt;

  // Floor numbers 1..4 coincide with their 3-bit codes, so the floor register is the output code.
  assign target    = {z1, z2, z3};
  assign target_ok = (target >= 3'd1) && (target <= 3'd4);
  assign floor_up  = floor + 3'd1;
  assign floor_dn  = floor - 3'd1;
  assign {f1, f2, f3} = floor;

`ifdef LIFT_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      floor      <= 3'd1;
      travel_cnt <= '0;
      door_cnt   <= '0;
      up         <= 1'b0;
      down       <= 1'b0;
      door_open  <= 1'b0;
      arrive     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          travel_cnt <= '0;
          if (target_ok && (target > floor)) begin
            state <= MV_UP;
            up    <= 1'b1;
          end else if (target_ok && (target < floor)) begin
            state <= MV_DN;
            down  <= 1'b1;
          end
        end
        MV_UP: begin
          if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt <= '0;
            floor      <= floor_up;
            // Reaching the target, a reversed or invalid target, or the top floor all stop here.
            if (!(target_ok && (target > floor_up))) begin
              state     <= DOOR;
              up        <= 1'b0;
              door_open <= 1'b1;
              arrive    <= 1'b1;
              door_cnt  <= '0;
            end
          end else begin
            travel_cnt <= travel_cnt + 26'd1;
          end
        end
        MV_DN: begin
          if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt <= '0;
            floor      <= floor_dn;
            if (!(target_ok && (target < floor_dn))) begin
              state     <= DOOR;
              down      <= 1'b0;
              door_open <= 1'b1;
              arrive    <= 1'b1;
              door_cnt  <= '0;
            end
          end else begin
            travel_cnt <= travel_cnt + 26'd1;
          end
        end
        DOOR: begin
          arrive <= 1'b0;
          if (hold) begin
            door_cnt <= '0;
          end else if (door_cnt == DOOR_LAST) begin
            door_cnt  <= '0;
            door_open <= 1'b0;
            state     <= IDLE;
          end else begin
            door_cnt <= door_cnt + 27'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
